// File: rtl/query_frame_rx.sv
// Host-link frame receiver: detects new words, assembles SYNC/query/k/checksum frames,
// and hands a validated query vector and k downstream over valid/ready.
module query_frame_rx #(
  parameter int              WIDTH          = 32,
  parameter int              DIM            = 4,
  parameter int              K_WIDTH        = 16,
  parameter logic [WIDTH-1:0] SYNC_WORD     = 32'hFFFFFFFF,
  parameter int              CHECKSUM_EN    = 1,
  parameter int              STROBE_MODE    = 0,
  parameter int              TIMEOUT_CYCLES = 10000000
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [WIDTH-1:0]              word_in,
  input  logic                          word_strobe_in,
  input  logic                          ready_in,
  output logic [DIM-1:0][WIDTH-1:0]     query_out,
  output logic [K_WIDTH-1:0]            k_out,
  output logic                          valid_out,
  output logic                          busy_out,
  output logic                          err_out,
  output logic [15:0]                   frame_count_out,
  output logic [15:0]                   err_count_out
);

  localparam int IW = $clog2(DIM + 1);
  localparam int SW = $clog2(DIM);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, CHECK, HOLD} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   word_prev;
  logic [WIDTH-1:0]   buffer [DIM];
  logic [K_WIDTH-1:0] k_buf;
  logic [WIDTH-1:0]   acc;
  logic [IW-1:0]      idx;
  logic [TW-1:0]      timer;

  logic new_word, is_sync, timeout_hit;
  logic start, store, accept, deliver, err;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign new_word    = (STROBE_MODE != 0) ? word_strobe_in : (word_in != word_prev);
  assign is_sync     = (word_in == SYNC_WORD);
  assign timeout_hit = ((state == COLLECT) || (state == CHECK)) && !new_word &&
                       (timer == TW'(TIMEOUT_CYCLES - 1));
  assign busy_out    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    store     = 1'b0;
    accept    = 1'b0;
    deliver   = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (new_word && is_sync) begin
          start     = 1'b1;
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (new_word) begin
          if (is_sync) begin
            err   = 1'b1;
            start = 1'b1;
          end else begin
            store = 1'b1;
            if (idx == IW'(DIM)) begin
              if (CHECKSUM_EN != 0) begin
                state_nxt = CHECK;
              end else begin
                accept    = 1'b1;
                state_nxt = HOLD;
              end
            end
          end
        end else if (timeout_hit) begin
          err       = 1'b1;
          state_nxt = IDLE;
        end
      end
      CHECK: begin
        if (new_word) begin
          if (is_sync) begin
            err       = 1'b1;
            start     = 1'b1;
            state_nxt = COLLECT;
          end else if (word_in == acc) begin
            accept    = 1'b1;
            state_nxt = HOLD;
          end else begin
            err       = 1'b1;
            state_nxt = IDLE;
          end
        end else if (timeout_hit) begin
          err       = 1'b1;
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (valid_out && ready_in) begin
          deliver   = 1'b1;
          state_nxt = IDLE;
        end
        // Words arriving while a frame is parked are overruns; a SYNC here is harmless.
        if (new_word && !is_sync) err = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= IDLE;
      word_prev       <= '0;
      idx             <= '0;
      timer           <= '0;
      query_out       <= '0;
      k_out           <= '0;
      valid_out       <= 1'b0;
      err_out         <= 1'b0;
      frame_count_out <= '0;
      err_count_out   <= '0;
    end else begin
      state     <= state_nxt;
      word_prev <= word_in;
      err_out   <= err;
      if (err) err_count_out <= sat_inc(err_count_out);

      if (start) begin
        idx   <= '0;
        acc   <= '0;
        timer <= '0;
      end else if ((state == COLLECT) || (state == CHECK)) begin
        timer <= new_word ? '0 : timer + TW'(1);
      end

      if (store) begin
        if (idx == IW'(DIM)) k_buf <= word_in[K_WIDTH-1:0];
        else                 buffer[idx[SW-1:0]] <= word_in;
        acc <= acc ^ word_in;
        idx <= idx + IW'(1);
      end

      // Without a checksum the k word is accepted on the same edge it arrives.
      if (accept) begin
        for (int i = 0; i < DIM; i++) query_out[i] <= buffer[i];
        k_out     <= (CHECKSUM_EN != 0) ? k_buf : word_in[K_WIDTH-1:0];
        valid_out <= 1'b1;
      end

      if (deliver) begin
        valid_out       <= 1'b0;
        frame_count_out <= frame_count_out + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_query_frame_rx.sv
// Directed bench: strobe/checksum instance (a) and level-change/no-checksum instance (b).
module tb_query_frame_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_a, strb_a, rdy_a;
  logic [31:0]       word_a;
  logic [3:0][31:0]  q_a;
  logic [15:0]       k_a, fc_a, ec_a;
  logic              vld_a, busy_a, err_a;

  logic              rst_b, strb_b, rdy_b;
  logic [31:0]       word_b;
  logic [3:0][31:0]  q_b;
  logic [15:0]       k_b, fc_b, ec_b;
  logic              vld_b, busy_b, err_b;

  int n_checks = 0;
  int n_pass   = 0;

  query_frame_rx #(.CHECKSUM_EN(1), .STROBE_MODE(1), .TIMEOUT_CYCLES(100)) dut_a (
    .clk_in(clk), .rst_in(rst_a), .word_in(word_a), .word_strobe_in(strb_a),
    .ready_in(rdy_a), .query_out(q_a), .k_out(k_a), .valid_out(vld_a),
    .busy_out(busy_a), .err_out(err_a), .frame_count_out(fc_a), .err_count_out(ec_a));

  query_frame_rx #(.CHECKSUM_EN(0), .STROBE_MODE(0), .TIMEOUT_CYCLES(1000)) dut_b (
    .clk_in(clk), .rst_in(rst_b), .word_in(word_b), .word_strobe_in(strb_b),
    .ready_in(rdy_b), .query_out(q_b), .k_out(k_b), .valid_out(vld_b),
    .busy_out(busy_b), .err_out(err_b), .frame_count_out(fc_b), .err_count_out(ec_b));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [31:0] w);
    word_a = w;
    strb_a = 1'b1;
    tick();
    strb_a = 1'b0;
  endtask

  task automatic level_b(input logic [31:0] w);
    word_b = w;
    repeat (50) tick();
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
  endtask

  task automatic handshake_a();
    rdy_a = 1'b1;
    tick();
    rdy_a = 1'b0;
  endtask

  task automatic check_q_a(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3, input logic [15:0] ek);
    check({tag, "_q0"}, q_a[0], e0);
    check({tag, "_q1"}, q_a[1], e1);
    check({tag, "_q2"}, q_a[2], e2);
    check({tag, "_q3"}, q_a[3], e3);
    check({tag, "_k"},  k_a,    ek);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; strb_a = 1'b0; rdy_a = 1'b0; word_a = '0;
    rst_b = 1'b1; strb_b = 1'b0; rdy_b = 1'b0; word_b = '0;
    repeat (2) tick();
    rst_a = 1'b0;
    rst_b = 1'b0;

    check("rst_valid", vld_a, 0);
    check("rst_busy",  busy_a, 0);
    check("rst_err",   err_a, 0);
    check("rst_fc",    fc_a, 0);
    check("rst_ec",    ec_a, 0);
    check_q_a("rst", 0, 0, 0, 0, 0);

    // Good frame with checksum
    send_a(32'hFFFFFFFF); send_a(5); send_a(7); send_a(1); send_a(1); send_a(4);
    check("t1_valid_before_cs", vld_a, 0);
    check("t1_busy", busy_a, 1);
    send_a(6);
    check("t1_valid_latency", vld_a, 1);
    check_q_a("t1", 5, 7, 1, 1, 4);
    tick();
    check("t1_valid_held", vld_a, 1);
    check("t1_fc_before_ready", fc_a, 0);
    handshake_a();
    check("t1_fc", fc_a, 1);
    check("t1_valid_drop", vld_a, 0);
    check("t1_busy_idle", busy_a, 0);

    // Bad checksum
    reset_a();
    send_a(32'hFFFFFFFF); send_a(5); send_a(7); send_a(1); send_a(1); send_a(4);
    send_a(7);
    check("t2_err_pulse", err_a, 1);
    tick();
    check("t2_err_one_cycle", err_a, 0);
    check("t2_ec", ec_a, 1);
    check("t2_valid", vld_a, 0);
    check("t2_busy", busy_a, 0);
    check_q_a("t2", 0, 0, 0, 0, 0);

    // Resync mid-frame
    reset_a();
    send_a(32'hFFFFFFFF); send_a(5); send_a(7);
    send_a(32'hFFFFFFFF);
    check("t3_resync_err", err_a, 1);
    send_a(1); send_a(2); send_a(3); send_a(4); send_a(2);
    send_a(6);
    check("t3_ec", ec_a, 1);
    check("t3_valid", vld_a, 1);
    check_q_a("t3", 1, 2, 3, 4, 2);
    handshake_a();
    check("t3_fc", fc_a, 1);

    // Timeout after 100 idle cycles
    reset_a();
    send_a(32'hFFFFFFFF); send_a(5);
    repeat (99) tick();
    check("t4_no_early_timeout", err_a, 0);
    check("t4_busy_waiting", busy_a, 1);
    tick();
    check("t4_timeout_err", err_a, 1);
    check("t4_ec", ec_a, 1);
    check("t4_idle", busy_a, 0);
    send_a(32'hFFFFFFFF); send_a(1); send_a(2); send_a(3); send_a(4); send_a(5);
    send_a(1);
    check("t4_valid", vld_a, 1);
    check_q_a("t4", 1, 2, 3, 4, 5);
    handshake_a();
    check("t4_fc", fc_a, 1);

    // Overrun words while parked in HOLD, SYNC ignored there
    send_a(32'hFFFFFFFF); send_a(9); send_a(8); send_a(7); send_a(6); send_a(3); send_a(3);
    check("t4b_valid", vld_a, 1);
    send_a(32'h11);
    check("t4b_overrun_err", err_a, 1);
    check("t4b_ec_overrun", ec_a, 2);
    send_a(32'hFFFFFFFF);
    check("t4b_sync_in_hold_no_err", err_a, 0);
    check("t4b_ec_sync_hold", ec_a, 2);
    handshake_a();
    check("t4b_fc", fc_a, 2);

    // Reset mid-frame clears counters and outputs
    send_a(32'hFFFFFFFF); send_a(1); send_a(2); send_a(3);
    reset_a();
    check("t6_fc", fc_a, 0);
    check("t6_ec", ec_a, 0);
    check("t6_valid", vld_a, 0);
    check("t6_busy", busy_a, 0);
    check_q_a("t6_rst", 0, 0, 0, 0, 0);
    send_a(32'hFFFFFFFF); send_a(9); send_a(8); send_a(7); send_a(6); send_a(3);
    send_a(3);
    check("t6_valid_after", vld_a, 1);
    check_q_a("t6", 9, 8, 7, 6, 3);

    // Level-change detection without checksum
    level_b(32'hFFFFFFFF); level_b(3); level_b(9); level_b(2); level_b(8); level_b(1);
    check("t5_valid", vld_b, 1);
    check("t5_q0", q_b[0], 3);
    check("t5_q1", q_b[1], 9);
    check("t5_q2", q_b[2], 2);
    check("t5_q3", q_b[3], 8);
    check("t5_k",  k_b, 1);
    check("t5_ec0", ec_b, 0);
    level_b(5);
    check("t5_ec1", ec_b, 1);
    level_b(6);
    check("t5_ec2", ec_b, 2);
    check("t5_valid_held", vld_b, 1);
    check("t5_q_held", q_b[1], 9);
    rdy_b = 1'b1;
    tick();
    rdy_b = 1'b0;
    check("t5_fc", fc_b, 1);
    check("t5_valid_drop", vld_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
